// File: rtl/lopd_norm_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | lopd_norm_pipe                                                            |
// | Two-stage leading/trailing-one detector and normaliser, valid/ready.      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module lopd_norm_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  localparam int POS_W = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_mode,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [POS_W-1:0]  o_pos_one,
  output logic              o_zero_flag,
  output logic [POS_W:0]    o_shift,
  output logic [DATA_W-1:0] o_norm,
  output logic              o_mode,
  output logic [TAG_W-1:0]  o_tag
);

  localparam int             c_NG         = DATA_W / 8;
  localparam logic [POS_W:0] c_SHIFT_ZERO = (POS_W+1)'(DATA_W);
  localparam logic [POS_W:0] c_MAX_POS    = (POS_W+1)'(DATA_W - 1);

  logic                  r_v1;
  logic                  r_v2;
  logic                  w_en1;
  logic                  w_en2;

  logic [c_NG-1:0][2:0]  w_grp_lead;
  logic [c_NG-1:0][2:0]  w_grp_trail;
  logic [c_NG-1:0]       w_grp_zero;
  logic [c_NG-1:0][2:0]  r_s1_lead;
  logic [c_NG-1:0][2:0]  r_s1_trail;
  logic [c_NG-1:0]       r_s1_zero;
  logic [DATA_W-1:0]     r_s1_data;
  logic                  r_s1_mode;
  logic [TAG_W-1:0]      r_s1_tag;

  logic [POS_W-1:0]      w_pos;
  logic                  w_zero;
  logic [POS_W:0]        w_shift;
  logic [DATA_W-1:0]     w_norm;

  logic [POS_W-1:0]      r_pos;
  logic                  r_zero;
  logic [POS_W:0]        r_shift;
  logic [DATA_W-1:0]     r_norm;
  logic                  r_mode;
  logic [TAG_W-1:0]      r_tag;

  assign w_en2   = !r_v2 | i_ready;
  assign w_en1   = !r_v1 | w_en2;
  assign o_ready = w_en1;

  // Per-byte priority encoders: later loop iterations win.
  always_comb begin
    w_grp_lead  = '0;
    w_grp_trail = '0;
    w_grp_zero  = '0;
    for (int g = 0; g < c_NG; g++) begin
      w_grp_zero[g] = ~|i_data[g*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        if (i_data[g*8 + b]) w_grp_lead[g] = 3'(b);
      end
      for (int b = 7; b >= 0; b--) begin
        if (i_data[g*8 + b]) w_grp_trail[g] = 3'(b);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= i_valid;
      if (w_en2) r_v2 <= r_v1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_lead  <= '0;
      r_s1_trail <= '0;
      r_s1_zero  <= '0;
      r_s1_data  <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_en1 && i_valid) begin
      r_s1_lead  <= w_grp_lead;
      r_s1_trail <= w_grp_trail;
      r_s1_zero  <= w_grp_zero;
      r_s1_data  <= i_data;
      r_s1_mode  <= i_mode;
      r_s1_tag   <= i_tag;
    end
  end

  // Group index supplies the upper position bits, the in-byte position the low three.
  always_comb begin
    w_pos  = '0;
    w_zero = &r_s1_zero;
    if (r_s1_mode) begin
      for (int g = c_NG - 1; g >= 0; g--) begin
        if (!r_s1_zero[g]) w_pos = POS_W'(g * 8) | POS_W'(r_s1_trail[g]);
      end
    end else begin
      for (int g = 0; g < c_NG; g++) begin
        if (!r_s1_zero[g]) w_pos = POS_W'(g * 8) | POS_W'(r_s1_lead[g]);
      end
    end
    if (w_zero) begin
      w_shift = c_SHIFT_ZERO;
    end else if (r_s1_mode) begin
      w_shift = {1'b0, w_pos};
    end else begin
      w_shift = c_MAX_POS - {1'b0, w_pos};
    end
    w_norm = r_s1_mode ? (r_s1_data >> w_shift) : (r_s1_data << w_shift);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos   <= '0;
      r_zero  <= 1'b0;
      r_shift <= '0;
      r_norm  <= '0;
      r_mode  <= 1'b0;
      r_tag   <= '0;
    end else if (w_en2 && r_v1) begin
      r_pos   <= w_pos;
      r_zero  <= w_zero;
      r_shift <= w_shift;
      r_norm  <= w_norm;
      r_mode  <= r_s1_mode;
      r_tag   <= r_s1_tag;
    end
  end

  assign o_valid     = r_v2;
  assign o_pos_one   = r_pos;
  assign o_zero_flag = r_zero;
  assign o_shift     = r_shift;
  assign o_norm      = r_norm;
  assign o_mode      = r_mode;
  assign o_tag       = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_lopd_norm_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_lopd_norm_pipe                                                         |
// | Directed and randomized checks of lopd_norm_pipe against a bit-loop model.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_lopd_norm_pipe;

  typedef struct {
    int          pos;
    logic        z;
    int          sh;
    logic [63:0] nm;
    logic        m;
    logic [3:0]  t;
  } exp_t;

  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  logic rand_go  = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        tv, tm, tr;
  logic [31:0] tdata;
  logic [3:0]  tt;
  logic        ordy, ov, oz, om;
  logic [4:0]  opos;
  logic [5:0]  osh;
  logic [31:0] onorm;
  logic [3:0]  ot;

  lopd_norm_pipe #(.DATA_W(32), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(tv), .o_ready(ordy), .i_data(tdata),
    .i_mode(tm), .i_tag(tt), .o_valid(ov), .i_ready(tr), .o_pos_one(opos),
    .o_zero_flag(oz), .o_shift(osh), .o_norm(onorm), .o_mode(om), .o_tag(ot)
  );

  // Reference: scan bits directly, then shift by the resulting distance.
  function automatic exp_t ref_model(logic [63:0] d, int w, logic m, logic [3:0] t);
    exp_t        e;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = d & mask;
    e.m  = m;
    e.t  = t;
    e.z  = (d == 64'd0);
    e.pos = 0;
    if (e.z) begin
      e.sh = w;
      e.nm = 64'd0;
    end else if (!m) begin
      for (int i = 0; i < w; i++) if (d[i]) e.pos = i;
      e.sh = w - 1 - e.pos;
      e.nm = (d << e.sh) & mask;
    end else begin
      for (int i = w - 1; i >= 0; i--) if (d[i]) e.pos = i;
      e.sh = e.pos;
      e.nm = d >> e.sh;
    end
    return e;
  endfunction

  function automatic logic [63:0] gen(int w);
    logic [63:0] d;
    case ($urandom_range(0, 7))
      0:       d = 64'd0;
      1, 2:    d = 64'd1 << $urandom_range(0, w - 1);
      3, 4:    d = (64'd1 << $urandom_range(0, w - 1)) | (64'd1 << $urandom_range(0, w - 1))
                   | (64'd1 << $urandom_range(0, w - 1));
      default: d = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    return d;
  endfunction

  task automatic push(input logic [31:0] d, input logic m, input logic [3:0] t);
    @(negedge clk);
    tv = 1'b1; tdata = d; tm = m; tt = t;
    @(posedge clk);
    #1 tv = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if (ov !== 1'b0)       begin errors++; $display("FAIL reset_valid got=%b exp=0", ov); end
    checks++; if (opos !== 5'd0)     begin errors++; $display("FAIL reset_pos got=%0d exp=0", opos); end
    checks++; if (oz !== 1'b0)       begin errors++; $display("FAIL reset_zero got=%b exp=0", oz); end
    checks++; if (osh !== 6'd0)      begin errors++; $display("FAIL reset_shift got=%0d exp=0", osh); end
    checks++; if (onorm !== 32'd0)   begin errors++; $display("FAIL reset_norm got=%h exp=0", onorm); end
    checks++; if (om !== 1'b0 || ot !== 4'd0) begin errors++; $display("FAIL reset_mode_tag got=%b/%h exp=0/0", om, ot); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    checks++; if (ordy !== 1'b1)     begin errors++; $display("FAIL reset_ready got=%b exp=1", ordy); end
  endtask

  task automatic test_leading;
    push(32'h0000_0100, 1'b0, 4'd5);
    @(negedge clk);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL lead_early_valid got=%b exp=0", ov); end
    @(negedge clk);
    checks++; if (ov !== 1'b1)           begin errors++; $display("FAIL lead_valid got=%b exp=1", ov); end
    checks++; if (opos !== 5'd8)         begin errors++; $display("FAIL lead_pos got=%0d exp=8", opos); end
    checks++; if (osh !== 6'd23)         begin errors++; $display("FAIL lead_shift got=%0d exp=23", osh); end
    checks++; if (onorm !== 32'h8000_0000) begin errors++; $display("FAIL lead_norm got=%h exp=80000000", onorm); end
    checks++; if (oz !== 1'b0 || ot !== 4'd5 || om !== 1'b0) begin
      errors++; $display("FAIL lead_side got z=%b tag=%h mode=%b exp z=0 tag=5 mode=0", oz, ot, om);
    end
  endtask

  task automatic test_trailing;
    push(32'h0F00_0030, 1'b1, 4'd9);
    @(negedge clk);
    @(negedge clk);
    checks++; if (ov !== 1'b1 || opos !== 5'd4 || osh !== 6'd4 || onorm !== 32'h00F0_0003 || om !== 1'b1 || ot !== 4'd9) begin
      errors++;
      $display("FAIL trail got v=%b pos=%0d sh=%0d norm=%h mode=%b tag=%h exp v=1 pos=4 sh=4 norm=00f00003 mode=1 tag=9",
               ov, opos, osh, onorm, om, ot);
    end
  endtask

  task automatic test_zero_extremes;
    logic [31:0] a_d[6]  = '{32'h0, 32'h0, 32'h8000_0000, 32'h1, 32'h1, 32'h8000_0000};
    logic        a_m[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0]  a_p[6]  = '{5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd31};
    logic        a_z[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0]  a_s[6]  = '{6'd32, 6'd32, 6'd0, 6'd31, 6'd0, 6'd31};
    logic [31:0] a_n[6]  = '{32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1};
    for (int i = 0; i < 6; i++) begin
      push(a_d[i], a_m[i], 4'(i));
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ov !== 1'b1 || opos !== a_p[i] || oz !== a_z[i] || osh !== a_s[i] || onorm !== a_n[i] || ot !== 4'(i)) begin
        errors++;
        $display("FAIL extreme[%0d] got v=%b pos=%0d z=%b sh=%0d norm=%h tag=%h exp v=1 pos=%0d z=%b sh=%0d norm=%h tag=%h",
                 i, ov, opos, oz, osh, onorm, ot, a_p[i], a_z[i], a_s[i], a_n[i], i);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e;
    int   sent, recv, occ, cyc;
    logic acc, in_x, out_x;
    sent = 0; recv = 0; occ = 0; cyc = 0; acc = 1'b0;
    while (recv < 6 && cyc < 40) begin
      @(negedge clk);
      if (acc) begin tv = 1'b0; acc = 1'b0; end
      if (!tv && sent < 6) begin
        tdata = 32'(gen(32)); tm = 1'($urandom_range(0, 1)); tt = 4'(sent); tv = 1'b1;
      end
      tr = (cyc < 2 || cyc >= 5);
      #4;
      checks++;
      if (ordy !== (occ < 2 || tr)) begin
        errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, ordy, (occ < 2 || tr));
      end
      if (ov) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious cyc=%0d o_valid with nothing in flight", cyc);
        end else if (int'(opos) !== q[0].pos || oz !== q[0].z || int'(osh) !== q[0].sh
                     || 64'(onorm) !== q[0].nm || om !== q[0].m || ot !== q[0].t) begin
          errors++;
          $display("FAIL b2b_item cyc=%0d got pos=%0d sh=%0d norm=%h tag=%h exp pos=%0d sh=%0d norm=%h tag=%h",
                   cyc, opos, osh, onorm, ot, q[0].pos, q[0].sh, q[0].nm[31:0], q[0].t);
        end
      end
      in_x  = tv && ordy;
      out_x = ov && tr;
      if (out_x && q.size() > 0) begin void'(q.pop_front()); recv++; end
      if (in_x) begin
        e = ref_model(64'(tdata), 32, tm, tt);
        q.push_back(e); sent++; acc = 1'b1;
      end
      occ = occ + int'(in_x) - int'(out_x);
      cyc++;
    end
    @(negedge clk) tv = 1'b0; tr = 1'b1;
    checks++; if (recv != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", recv); end
  endtask

  task automatic test_reset_mid;
    tr = 1'b0;
    push(32'h0000_00F0, 1'b0, 4'd1);
    push(32'h0000_0F00, 1'b1, 4'd2);
    @(negedge clk);
    checks++; if (ov !== 1'b1 || ordy !== 1'b0) begin errors++; $display("FAIL mid_full got v=%b rdy=%b exp v=1 rdy=0", ov, ordy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", ov); end
    @(negedge clk) rst_n = 1'b1; tr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d] got=%b exp=0", i, ov); end
    end
    push(32'h0001_0000, 1'b0, 4'hA);
    @(negedge clk);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_new_early got=%b exp=0", ov); end
    @(negedge clk);
    checks++; if (ov !== 1'b1 || opos !== 5'd16 || osh !== 6'd15 || ot !== 4'hA) begin
      errors++; $display("FAIL mid_new got v=%b pos=%0d sh=%0d tag=%h exp v=1 pos=16 sh=15 tag=a", ov, opos, osh, ot);
    end
  endtask

  task automatic test_random;
    int c;
    rand_go = 1'b1;
    c = 0;
    while (done_cnt < 4 && c < 60000) begin
      @(posedge clk);
      c++;
    end
    checks++; if (done_cnt != 4) begin errors++; $display("FAIL rand_done got=%0d exp=4", done_cnt); end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_w
    localparam int W  = 8 << gi;
    localparam int PW = $clog2(W);
    localparam int N  = 2500;
    logic          rv, rrdy, rm, ordy_w, ov_w, oz_w, om_w;
    logic [W-1:0]  rd, on_w;
    logic [3:0]    rt, ot_w;
    logic [PW-1:0] op_w;
    logic [PW:0]   os_w;
    exp_t          q[$];

    lopd_norm_pipe #(.DATA_W(W), .TAG_W(4)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(rv), .o_ready(ordy_w), .i_data(rd),
      .i_mode(rm), .i_tag(rt), .o_valid(ov_w), .i_ready(rrdy), .o_pos_one(op_w),
      .o_zero_flag(oz_w), .o_shift(os_w), .o_norm(on_w), .o_mode(om_w), .o_tag(ot_w)
    );

    initial begin
      int          sent, recv, cyc;
      logic        acc;
      logic [63:0] d64;
      rv = 1'b0; rrdy = 1'b1; rd = '0; rm = 1'b0; rt = '0;
      sent = 0; recv = 0; cyc = 0; acc = 1'b0;
      wait (rand_go);
      while (recv < N && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (acc) begin rv = 1'b0; acc = 1'b0; end
        if (!rv && sent < N && $urandom_range(0, 3) != 0) begin
          d64 = gen(W);
          rd = d64[W-1:0]; rm = 1'($urandom_range(0, 1)); rt = 4'($urandom); rv = 1'b1;
        end
        rrdy = ($urandom_range(0, 3) != 0);
        #4;
        if (ov_w) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL rand_w%0d spurious o_valid", W);
          end else if (int'(op_w) !== q[0].pos || oz_w !== q[0].z || int'(os_w) !== q[0].sh
                       || 64'(on_w) !== q[0].nm || om_w !== q[0].m || ot_w !== q[0].t) begin
            errors++;
            $display("FAIL rand_w%0d item %0d got pos=%0d z=%b sh=%0d norm=%h tag=%h exp pos=%0d z=%b sh=%0d norm=%h tag=%h",
                     W, recv, op_w, oz_w, os_w, on_w, ot_w, q[0].pos, q[0].z, q[0].sh, q[0].nm, q[0].t);
          end
          if (rrdy && q.size() > 0) begin void'(q.pop_front()); recv++; end
        end
        if (rv && ordy_w) begin
          q.push_back(ref_model(64'(rd), W, rm, rt));
          sent++; acc = 1'b1;
        end
      end
      @(negedge clk) rv = 1'b0;
      checks++;
      if (recv != N) begin errors++; $display("FAIL rand_w%0d count got=%0d exp=%0d", W, recv, N); end
      done_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; tv = 1'b0; tr = 1'b1; tm = 1'b0; tt = 4'd0; tdata = 32'd0;
    repeat (2) @(posedge clk);
    test_reset;
    test_leading;
    test_trailing;
    test_zero_extremes;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(negedge clk);
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lopd_norm_pipe.md
# lopd_norm_pipe

Parametrised, pipelined leading/trailing-one position detector with normaliser, for the floating-point add/sub datapath after mantissa subtraction. It takes a DATA_W-bit magnitude under a valid/ready handshake and returns four results two cycles later: the position of the leading (or trailing) one, a zero flag, the shift count, and the normalised data. A sideband tag travels with each item. Unlike the fixed 16-bit combinational detector, it is width-generic, registered, back-pressurable and has a trailing-one mode.

## Interface
- DATA_W, 32: data width; power of two, 8..64.
- TAG_W, 4: sideband tag width, ≥1, carried unmodified.
- POS_W, $clog2(DATA_W): position width (derived, not overridden).
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input item valid.
- o_ready  out  1  block can accept an input this cycle.
- i_data  in  DATA_W  magnitude to scan.
- i_mode  in  1  0 = leading-one (MSB side), 1 = trailing-one (LSB side).
- i_tag  in  TAG_W  sideband.
- o_valid  out  1  output item valid.
- i_ready  in  1  downstream accepts output.
- o_pos_one  out  POS_W  bit index of detected one.
- o_zero_flag  out  1  i_data was all zeros.
- o_shift  out  POS_W+1  normalisation shift count.
- o_norm  out  DATA_W  normalised data.
- o_mode  out  1  registered copy of i_mode.
- o_tag  out  TAG_W  registered copy of i_tag.

## Operation
- Stage 1 (S1):
  - Split i_data into DATA_W/8 byte groups.
  - Per group, register the 3-bit leading-one position, 3-bit trailing-one position and zero flag.
  - Also register the data, mode and tag.
- Stage 2 (S2):
  - Combine groups by priority into o_pos_one and o_zero_flag: highest non-zero group for mode 0, lowest for mode 1.
  - Compute o_shift and o_norm, then register all outputs.
- Mode 0: o_pos_one = index of highest set bit; o_shift = DATA_W-1-o_pos_one; o_norm = data << o_shift (MSB of o_norm is 1).
- Mode 1: o_pos_one = index of lowest set bit; o_shift = o_pos_one; o_norm = data >> o_shift (LSB of o_norm is 1).
- Zero input, either mode: o_zero_flag=1, o_pos_one=0, o_shift=DATA_W, o_norm=0.
- o_shift never exceeds DATA_W. Shifts are logical and zero-filled.
- Handshake:
  - An input transfer occurs when i_valid & o_ready.
  - An output transfer occurs when o_valid & i_ready.
  - While i_valid & !o_ready, inputs must be held stable by the source.
  - o_valid, once asserted, stays asserted and all outputs stay stable until transfer.
- Stall logic, per-stage valid bits v1 and v2:
  - en2 = !v2 | i_ready.
  - en1 = !v1 | en2.
  - o_ready = en1; it depends combinationally on i_ready, with no registered skid.
- No bubbles: with i_ready held 1, one item per cycle is accepted and delivered.
- Order is preserved. Items are never dropped or duplicated.

## Timing
- Latency: exactly 2 cycles from input transfer to o_valid, when no stall occurs.
- Throughput: 1 item/cycle. Capacity: 2 items in flight.
- Reset (i_rst_n low, async):
  - v1=v2=0, so o_valid=0.
  - o_pos_one=0, o_zero_flag=0, o_shift=0, o_norm=0, o_mode=0, o_tag=0.
  - o_ready=1 from the first cycle after reset release.
- Reset mid-operation discards all in-flight items. No output is produced for them after release.
- Full pipe with i_ready=0:
  - o_ready=0.
  - S1 and S2 contents hold bit-exact until i_ready rises.
- Simultaneous events: an input transfer into a full pipe while an output transfer occurs in the same cycle is legal. Occupancy stays 2.
- Data registers may update when their valid bit is 0. Outputs are only meaningful while o_valid=1, except for the reset values above.

## Test plan
- Leading-one, DATA_W=32: i_data=0x0000_0100, mode 0, tag 5 -> 2 cycles later o_valid=1, o_pos_one=8, o_shift=23, o_norm=0x8000_0000, o_zero_flag=0, o_tag=5.
- Trailing-one: i_data=0x0F00_0030, mode 1 -> o_pos_one=4, o_shift=4, o_norm=0x00F0_0003.
- Zero/extremes:
  - i_data=0, either mode -> o_zero_flag=1, o_pos_one=0, o_shift=32, o_norm=0.
  - i_data=0x8000_0000, mode 0 -> pos 31, shift 0.
  - i_data=0x1, mode 0 -> pos 0, shift 31.
- Back-pressure stream:
  - Feed 6 back-to-back items while i_ready=1 for 2 cycles, 0 for 3 cycles, then 1.
  - Required: o_ready falls the cycle both stages are full.
  - All 6 outputs arrive in order, held stable during the stall, none lost or duplicated.
- Reset mid-stream: assert i_rst_n=0 with 2 items in flight -> o_valid=0 immediately; after release, no stale output appears and a new item emerges with 2-cycle latency.
- Random exhaustive check: compare against a reference model on 10k random items with random sparse data, random mode and random i_valid/i_ready toggling, for DATA_W in {8, 16, 32, 64}.
